// File: rtl/mcu_el2_dccm_zeroize.sv
// mcu_el2_dccm_zeroize: zero-fills every DCCM row with INIT_ECC after reset or on request, then passes core accesses straight through
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   zeroize_req                 single-cycle request to re-run the zero-fill pass
//   init_busy, init_done        pass in progress / last pass completed
//   core_access_err             registered pulse: the core enabled a bank while a pass was running
//   core_*                      per-bank DCCM request from the core and read data back to it
//   sram_*                      per-bank DCCM request to the macros and read data from them
module mcu_el2_dccm_zeroize #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int ECC_W = 7,
  parameter logic [ECC_W-1:0] INIT_ECC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        zeroize_req,
  output logic                        init_busy,
  output logic                        init_done,
  output logic                        core_access_err,
  input  logic [NUM_BANKS-1:0]        core_clken,
  input  logic [NUM_BANKS-1:0]        core_wren,
  input  logic [NUM_BANKS*ADDR_W-1:0] core_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] core_wr_data,
  input  logic [NUM_BANKS*ECC_W-1:0]  core_wr_ecc,
  output logic [NUM_BANKS*DATA_W-1:0] core_dout,
  output logic [NUM_BANKS*ECC_W-1:0]  core_ecc,
  output logic [NUM_BANKS-1:0]        sram_clken,
  output logic [NUM_BANKS-1:0]        sram_wren,
  output logic [NUM_BANKS*ADDR_W-1:0] sram_addr,
  output logic [NUM_BANKS*DATA_W-1:0] sram_wr_data,
  output logic [NUM_BANKS*ECC_W-1:0]  sram_wr_ecc,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout,
  input  logic [NUM_BANKS*ECC_W-1:0]  sram_ecc
);
  typedef enum logic {INIT, PASS} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic init_done_q, init_done_d, err_q, err_d;
  assign init_busy = state_q == INIT;
  assign init_done = init_done_q;
  assign core_access_err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    init_done_d = init_done_q;
    err_d = |core_clken & init_busy & ~rst;
    if (init_busy) begin
      // a request mid-pass restarts from row 0 and beats completion on the last row
      cnt_d = zeroize_req ? '0 : cnt_q + 1'b1;
      if (!zeroize_req && &cnt_q) begin
        state_d = PASS;
        init_done_d = 1'b1;
      end
    end else if (zeroize_req) begin
      state_d = INIT;
      cnt_d = '0;
      init_done_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      init_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_done_q <= init_done_d;
      err_q <= err_d;
    end
  end
  // read data arriving in the first busy cycle belongs to a pre-zeroize read and is squashed too
  always_comb begin
    sram_clken = rst ? '0 : init_busy ? '1 : core_clken;
    sram_wren = rst ? '0 : init_busy ? '1 : core_wren;
    sram_addr = init_busy ? {NUM_BANKS{cnt_q}} : core_addr;
    sram_wr_data = init_busy ? '0 : core_wr_data;
    sram_wr_ecc = init_busy ? {NUM_BANKS{INIT_ECC}} : core_wr_ecc;
    core_dout = init_busy ? '0 : sram_dout;
    core_ecc = init_busy ? '0 : sram_ecc;
  end
endmodule
